// File: rtl/led_blink_multi.sv
// led_blink_multi: N_CH LED channels (OFF/ON/BLINK/BURST) driven by a shared timebase tick.
// Optional build macro LED_SYNC_EN adds sync_in, a global restart of all channels and the prescaler.
//
// state | meaning
// B_ON  | led high phase (BLINK high half, BURST pulse high)
// B_OFF | led low phase (BLINK low half, BURST gap between pulses)
// PAUSE | BURST inter-burst pause, 4 half-periods long
module led_blink_multi #(
    parameter int CLK_HZ   = 100000000,
    parameter int TICK_HZ  = 1000,
    parameter int N_CH     = 2,
    parameter int PER_W    = 12,
    parameter int HALF_DEF = 250,
    localparam int CH_W    = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
`ifdef LED_SYNC_EN
    input  logic             sync_in,
`endif
    input  logic             cfg_we,
    input  logic [CH_W-1:0]  cfg_ch,
    input  logic [1:0]       cfg_mode,
    input  logic [PER_W-1:0] cfg_half,
    input  logic [3:0]       cfg_cnt,
    output logic [N_CH-1:0]  led,
    output logic             tick
);

    localparam int DIV   = CLK_HZ / TICK_HZ;
    localparam int DIV_W = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_M1 = DIV_W'(DIV - 1);
    localparam logic [DIV_W-1:0] PS_ONE = DIV_W'(1);
    localparam logic [PER_W+1:0] PH_ONE = (PER_W + 2)'(1);

    localparam logic [1:0] M_OFF   = 2'd0;
    localparam logic [1:0] M_ON    = 2'd1;
    localparam logic [1:0] M_BLINK = 2'd2;
    localparam logic [1:0] M_BURST = 2'd3;

    typedef enum logic [1:0] {
        B_ON  = 2'd0,
        B_OFF = 2'd1,
        PAUSE = 2'd2
    } bst_t;

    logic             w_sync;
    logic [DIV_W-1:0] r_presc;
    logic [DIV_W-1:0] w_presc_nx;
    logic             r_tick;

`ifdef LED_SYNC_EN
    assign w_sync = sync_in;
`else
    assign w_sync = 1'b0;
`endif

    always_comb begin
        if (w_sync || (r_presc == DIV_M1)) w_presc_nx = '0;
        else                               w_presc_nx = r_presc + PS_ONE;
    end

    // r_tick is high exactly while the prescaler holds DIV-1
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_presc <= '0;
            r_tick  <= 1'b0;
        end else begin
            r_presc <= w_presc_nx;
            r_tick  <= !w_sync && (w_presc_nx == DIV_M1);
        end
    end

    assign tick = r_tick;

    for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
        logic [1:0]       r_mode,  w_mode_nx;
        logic [PER_W-1:0] r_half,  w_half_nx;
        logic [3:0]       r_cnt,   w_cnt_nx;
        bst_t             r_state, w_state_nx;
        logic [PER_W+1:0] r_phase, w_phase_nx;
        logic [3:0]       r_pcnt,  w_pcnt_nx;
        logic             r_led,   w_led_nx;
        logic             w_wr;
        logic [PER_W-1:0] w_h;
        logic [PER_W+1:0] w_h_end;
        logic [PER_W+1:0] w_p_end;
        logic [3:0]       w_pcnt_inc;

        assign w_wr       = cfg_we && (cfg_ch == CH_W'(gi));
        assign w_h        = (r_half == '0) ? PER_W'(1) : r_half;
        assign w_h_end    = {2'b00, w_h} - PH_ONE;
        assign w_p_end    = {w_h, 2'b00} - PH_ONE;
        assign w_pcnt_inc = r_pcnt + 4'd1;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_mode  <= M_OFF;
                r_half  <= PER_W'(HALF_DEF);
                r_cnt   <= '0;
                r_state <= B_ON;
                r_phase <= '0;
                r_pcnt  <= '0;
                r_led   <= 1'b0;
            end else begin
                r_mode  <= w_mode_nx;
                r_half  <= w_half_nx;
                r_cnt   <= w_cnt_nx;
                r_state <= w_state_nx;
                r_phase <= w_phase_nx;
                r_pcnt  <= w_pcnt_nx;
                r_led   <= w_led_nx;
            end
        end

        // a write or sync restart takes precedence over a coincident tick
        always_comb begin
            w_mode_nx  = r_mode;
            w_half_nx  = r_half;
            w_cnt_nx   = r_cnt;
            w_state_nx = r_state;
            w_phase_nx = r_phase;
            w_pcnt_nx  = r_pcnt;
            if (w_wr || w_sync) begin
                if (w_wr) begin
                    w_mode_nx = cfg_mode;
                    w_half_nx = cfg_half;
                    w_cnt_nx  = cfg_cnt;
                end
                w_state_nx = B_ON;
                w_phase_nx = '0;
                w_pcnt_nx  = '0;
            end else if (r_tick) begin
                case (r_mode)
                    M_BLINK: begin
                        if (r_phase == w_h_end) begin
                            w_state_nx = (r_state == B_ON) ? B_OFF : B_ON;
                            w_phase_nx = '0;
                        end else begin
                            w_phase_nx = r_phase + PH_ONE;
                        end
                    end
                    M_BURST: begin
                        if (r_cnt != 4'd0) begin
                            case (r_state)
                                B_ON: begin
                                    if (r_phase == w_h_end) begin
                                        w_state_nx = B_OFF;
                                        w_phase_nx = '0;
                                    end else begin
                                        w_phase_nx = r_phase + PH_ONE;
                                    end
                                end
                                B_OFF: begin
                                    if (r_phase == w_h_end) begin
                                        w_phase_nx = '0;
                                        w_pcnt_nx  = w_pcnt_inc;
                                        w_state_nx = (w_pcnt_inc == r_cnt) ? PAUSE : B_ON;
                                    end else begin
                                        w_phase_nx = r_phase + PH_ONE;
                                    end
                                end
                                PAUSE: begin
                                    if (r_phase == w_p_end) begin
                                        w_state_nx = B_ON;
                                        w_phase_nx = '0;
                                        w_pcnt_nx  = '0;
                                    end else begin
                                        w_phase_nx = r_phase + PH_ONE;
                                    end
                                end
                                default: begin
                                    w_state_nx = B_ON;
                                    w_phase_nx = '0;
                                end
                            endcase
                        end
                    end
                    default: ;
                endcase
            end
        end

        always_comb begin
            w_led_nx = 1'b0;
            case (w_mode_nx)
                M_ON:    w_led_nx = 1'b1;
                M_BLINK: w_led_nx = (w_state_nx == B_ON);
                M_BURST: w_led_nx = (w_cnt_nx != 4'd0) && (w_state_nx == B_ON);
                default: w_led_nx = 1'b0;
            endcase
        end

        assign led[gi] = r_led;
    end

endmodule

// File: tb/tb_led_blink_multi.sv
// Directed bench for led_blink_multi (DIV=10, N_CH=2, PER_W=8) with a closed-form expected-LED model
// fed through a scoreboard queue; a second N_CH=3 instance exercises the out-of-range channel write.
module tb_led_blink_multi;

    localparam int DIV = 10;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cfg_we = 1'b0;
    logic       cfg_we3 = 1'b0;
    logic [0:0] cfg_ch = '0;
    logic [1:0] cfg_ch3 = '0;
    logic [1:0] cfg_mode = '0;
    logic [7:0] cfg_half = '0;
    logic [3:0] cfg_cnt = '0;
    logic [1:0] led;
    logic       tick;
    logic [2:0] led3;
    logic       tick3;
`ifdef LED_SYNC_EN
    logic       sync_in = 1'b0;
`endif

    always #5 clk = ~clk;

    led_blink_multi #(.CLK_HZ(1000), .TICK_HZ(100), .N_CH(2), .PER_W(8)) u_dut (
        .clk(clk),
        .rst_n(rst_n),
`ifdef LED_SYNC_EN
        .sync_in(sync_in),
`endif
        .cfg_we(cfg_we),
        .cfg_ch(cfg_ch),
        .cfg_mode(cfg_mode),
        .cfg_half(cfg_half),
        .cfg_cnt(cfg_cnt),
        .led(led),
        .tick(tick)
    );

    led_blink_multi #(.CLK_HZ(1000), .TICK_HZ(100), .N_CH(3), .PER_W(8)) u_dut3 (
        .clk(clk),
        .rst_n(rst_n),
`ifdef LED_SYNC_EN
        .sync_in(1'b0),
`endif
        .cfg_we(cfg_we3),
        .cfg_ch(cfg_ch3),
        .cfg_mode(cfg_mode),
        .cfg_half(cfg_half),
        .cfg_cnt(cfg_cnt),
        .led(led3),
        .tick(tick3)
    );

    typedef struct {
        logic [1:0] led;
        logic       tick;
        logic [2:0] led3;
    } exp_t;

    exp_t       q[$];
    int         n_assert = 0;
    int         n_fail = 0;
    int         cyc = 0;
    int         base = 0;
    int         kind[2] = '{0, 0};
    int         hh[2] = '{250, 250};
    int         cc[2] = '{0, 0};
    int         st[2] = '{0, 0};
    logic [2:0] exp3 = '0;

    // ticks consumed by the channels at edges in (a, e]
    function automatic int nticks(int a, int e);
        return (e - base) / DIV - (a - base) / DIV;
    endfunction

    function automatic logic exp_ch(int ch, int e);
        int n, h, per, p;
        h = (hh[ch] == 0) ? 1 : hh[ch];
        n = nticks(st[ch], e);
        case (kind[ch])
            1: return 1'b1;
            2: return ((n / h) % 2) == 0;
            3: begin
                if (cc[ch] == 0) return 1'b0;
                per = 2 * h * cc[ch] + 4 * h;
                p = n % per;
                return (p < 2 * h * cc[ch]) && (((p / h) % 2) == 0);
            end
            default: return 1'b0;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [2:0] obs, input logic [2:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s cyc=%0d: observed %0h expected %0h", tag, cyc, obs, expv);
        end
    endtask

    task automatic step();
        exp_t x;
        int   e;
        e = cyc + 1;
        x.led  = {exp_ch(1, e), exp_ch(0, e)};
        x.tick = ((e - base) % DIV) == DIV - 1;
        x.led3 = exp3;
        q.push_back(x);
        @(posedge clk);
        #1;
        cyc = e;
        x = q.pop_front();
        chk("led", {1'b0, led}, {1'b0, x.led});
        chk("tick", {2'b00, tick}, {2'b00, x.tick});
        chk("led3", led3, x.led3);
        chk("tick3", {2'b00, tick3}, {2'b00, x.tick});
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic wr(input int ch, input int mode, input int half, input int cnt);
        cfg_we   = 1'b1;
        cfg_ch   = 1'(ch);
        cfg_mode = 2'(mode);
        cfg_half = 8'(half);
        cfg_cnt  = 4'(cnt);
        kind[ch] = mode;
        hh[ch]   = half;
        cc[ch]   = cnt;
        st[ch]   = cyc + 1;
        step();
        cfg_we = 1'b0;
    endtask

    task automatic wr3(input int ch, input int mode);
        cfg_we3  = 1'b1;
        cfg_ch3  = 2'(ch);
        cfg_mode = 2'(mode);
        if (ch == 2) exp3[2] = (mode == 1);
        step();
        cfg_we3 = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        repeat (5) begin
            @(posedge clk);
            #1;
            chk("rst_led", {1'b0, led}, 3'b000);
            chk("rst_tick", {2'b00, tick}, 3'b000);
            chk("rst_led3", led3, 3'b000);
        end
        rst_n = 1'b1;
        cyc = 0;
        base = 0;
        run(33);

        wr(0, 2, 3, 0);
        run(140);
        wr(1, 3, 2, 3);
        run(324);
        chk("tick_before_coincident_write", {2'b00, tick}, 3'b001);
        wr(1, 1, 0, 0);
        run(60);
        wr(1, 2, 0, 0);
        run(60);

        wr3(2, 1);
        run(3);
        wr3(3, 1);
        run(5);

        wr(1, 3, 2, 3);
        chk("burst_start", {1'b0, led}, {1'b0, exp_ch(1, cyc), exp_ch(0, cyc)});
        run(25);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_led", {1'b0, led}, 3'b000);
        chk("async_rst_tick", {2'b00, tick}, 3'b000);
        chk("async_rst_led3", led3, 3'b000);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc = 0;
        base = 0;
        kind = '{0, 0};
        exp3 = '0;
        run(35);

`ifdef LED_SYNC_EN
        wr(0, 2, 3, 0);
        wr(1, 2, 5, 0);
        run(170);
        sync_in = 1'b1;
        base  = cyc + 1;
        st[0] = cyc + 1;
        st[1] = cyc + 1;
        step();
        sync_in = 1'b0;
        chk("sync_both_on", {1'b0, led}, 3'b011);
        run(80);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/led_blink_multi.md
Name: led_blink_multi

Overview:
- Parametrised multi-channel LED blinker. Successor to the fixed 2 Hz single-LED blinker.
- A shared prescaler produces a timebase tick. Each channel runs its own mode engine: OFF, ON, BLINK (programmable half-period) or BURST (N pulses then a pause).
- Channels are configured at run time through a simple write-strobe port driven by board-level control logic.
- Sits between the top-level control and the board LED pins.

Parameters:
- CLK_HZ, 100000000, input clock frequency in Hz.
- TICK_HZ, 1000, timebase tick rate. DIV = CLK_HZ/TICK_HZ; DIV must be >= 2.
- N_CH, 2, number of LED channels (1..16).
- PER_W, 12, width of the half-period field, in ticks.
- HALF_DEF, 250, reset half-period (250 ticks at 1 kHz = 2 Hz blink).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- cfg_we  in  1  config write strobe, one clk per write.
- cfg_ch  in  CH_W  target channel, where CH_W = max(1, clog2(N_CH)).
- cfg_mode  in  2  mode: 0 OFF, 1 ON, 2 BLINK, 3 BURST.
- cfg_half  in  PER_W  half-period in ticks.
- cfg_cnt  in  4  pulses per burst.
- led  out  N_CH  registered LED drive, active high.
- tick  out  1  one-clk pulse per timebase tick.

Behaviour:
- Reset (rst_n low, asynchronous, no clock needed):
  - led=0, tick=0, prescaler=0.
  - Every channel: mode=OFF, half=HALF_DEF, cnt=0, state=B_ON, phase=0, pulse count=0.
  - Release is synchronous to clk.
- Prescaler:
  - Counts 0..DIV-1 and wraps to 0.
  - tick=1 for exactly one clk while the count equals DIV-1.
  - First tick occurs DIV clks after reset release.
- Config write:
  - On the clk edge with cfg_we=1 and cfg_ch<N_CH, the channel latches mode/half/cnt and clears phase and pulse count.
  - Start state after write: OFF → led 0; ON → led 1; BLINK → led 1; BURST with cnt>0 → state B_ON, led 1.
  - Latency: new led value visible one clk after the write edge.
  - cfg_ch >= N_CH: write ignored, no channel changes.
  - Write coincident with tick: the written channel takes the write and ignores that tick; all other channels process the tick normally.
- Half-period: cfg_half=0 is treated as 1. Effective half H ranges 1..2^PER_W-1.
- OFF / ON modes: led held at 0 / 1; ticks are ignored.
- BLINK mode:
  - On each tick, phase increments.
  - When phase reaches H-1 on a tick: toggle led, phase back to 0.
  - Period = 2H ticks, 50% duty.
- BURST mode state machine, advancing on ticks only:
  - B_ON: led=1 for H ticks, then go to B_OFF.
  - B_OFF: led=0 for H ticks, then pulse count += 1. If count == cnt, go to PAUSE; otherwise go to B_ON.
  - PAUSE: led=0 for 4H ticks (counter width PER_W+2, no overflow), then count=0 and go to B_ON.
  - cnt=0: channel behaves as OFF.
- Channels are fully independent; the prescaler is shared.
- No combinational path from inputs to led or tick.

Optional Feature:
- Macro LED_SYNC_EN.
- Defined:
  - Adds input port sync_in (1 bit).
  - On a clk edge with sync_in=1, every channel restarts as if its current config had just been rewritten: phase and count cleared, start led value reapplied.
  - The prescaler is also cleared to 0.
  - sync_in has priority over a coincident tick.
  - A coincident cfg_we still applies its new config to the addressed channel; restart applies to all channels.
- Not defined: no sync_in port; behaviour otherwise identical.

Test Plan:
All scenarios use CLK_HZ=1000, TICK_HZ=100 (DIV=10), N_CH=2, PER_W=8.
- Reset/prescaler: hold rst_n=0 for 5 clk, then release → led=00, tick=0 during reset. First tick at clk 10 after release, then every 10 clk, each exactly 1 clk wide.
- BLINK: write ch0 mode=2 half=3 → led[0]=1 one clk after the write. led[0] falls after the 3rd tick and rises after the 6th; repeats with a 60-clk period. led[1] stays 0.
- BURST: write ch1 mode=3 half=2 cnt=3 → led[1] pattern in ticks: high2 low2 high2 low2 high2 low10, then repeats.
- Boundaries:
  - Write cfg_ch=1 mode=1 on the same clk as tick while ch0 blinks → led[1]=1 next clk; ch0 toggles on schedule.
  - Write cfg_half=0 → behaves as half=1, toggling every tick.
  - Write with cfg_ch beyond N_CH (e.g. CH_W=2, cfg_ch=3) → led unchanged.
- Reset mid-operation: assert rst_n=0 mid-burst between clk edges → led=00 immediately, before any clk edge. After release, both channels are OFF and half=HALF_DEF.
- LED_SYNC_EN build: ch0 BLINK half=3, ch1 BLINK half=5, run 17 ticks, then pulse sync_in → both led bits =1 next clk. Next tick arrives 10 clk later. ch0 falls after 3 ticks, ch1 after 5.
